// File: rtl/sonar_scheduler.sv
// Fires the six rangers pair by pair, times both echoes of the active pair and
// publishes the distances in centimetres as three 16-bit pair words.
module sonar_scheduler #(
  parameter int TICK_DIV  = 50,
  parameter int TRIG_US   = 10,
  parameter int CM_US     = 58,
  parameter int WINDOW_US = 30000,
  parameter int GAP_US    = 10000
) (
  input  logic        theClock,
  input  logic        theReset,
  input  logic        enable,
  input  logic [5:0]  echo,
  output logic [5:0]  trig,
  output logic [15:0] sonar12,
  output logic [15:0] sonar34,
  output logic [15:0] sonar56,
  output logic        busy,
  output logic        cycle_done
);

  localparam int TMAX_A = (WINDOW_US > TRIG_US) ? WINDOW_US : TRIG_US;
  localparam int TMAX   = (GAP_US > TMAX_A) ? GAP_US : TMAX_A;
  localparam int TCW    = $clog2(TMAX) + 1;
  localparam int PW     = $clog2(TICK_DIV) + 1;
  localparam int CW     = $clog2(CM_US) + 1;

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_LISTEN, S_STORE, S_GAP} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     p_reg, p_next;
  logic [PW-1:0]  pre_reg, pre_next;
  logic [TCW-1:0] tcnt_reg, tcnt_next;
  logic           tick, entering, listen_end;

  logic [5:0]     echo_s1_reg, echo_s2_reg, echo_lvl_reg, echo_rise_reg, echo_fall_reg;
  logic [1:0]     act_lvl, act_rise, act_fall;
  logic [15:0]    dist_word;

  logic [5:0]     trig_reg;
  logic [15:0]    sonar12_reg, sonar34_reg, sonar56_reg;
  logic           busy_reg, cycle_done_reg;

  function automatic logic [5:0] pair_mask(input logic [1:0] p);
    case (p)
      2'd1:    pair_mask = 6'b001100;
      2'd2:    pair_mask = 6'b110000;
      default: pair_mask = 6'b000011;
    endcase
  endfunction

  // Level and edges leave the same register stage so they stay cycle-aligned.
  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      echo_s1_reg   <= '0;
      echo_s2_reg   <= '0;
      echo_lvl_reg  <= '0;
      echo_rise_reg <= '0;
      echo_fall_reg <= '0;
    end else begin
      echo_s1_reg   <= echo;
      echo_s2_reg   <= echo_s1_reg;
      echo_lvl_reg  <= echo_s2_reg;
      echo_rise_reg <= echo_s2_reg & ~echo_lvl_reg;
      echo_fall_reg <= ~echo_s2_reg & echo_lvl_reg;
    end
  end

  always_comb begin
    case (p_reg)
      2'd1: begin
        act_lvl  = echo_lvl_reg[3:2];
        act_rise = echo_rise_reg[3:2];
        act_fall = echo_fall_reg[3:2];
      end
      2'd2: begin
        act_lvl  = echo_lvl_reg[5:4];
        act_rise = echo_rise_reg[5:4];
        act_fall = echo_fall_reg[5:4];
      end
      default: begin
        act_lvl  = echo_lvl_reg[1:0];
        act_rise = echo_rise_reg[1:0];
        act_fall = echo_fall_reg[1:0];
      end
    endcase
  end

  assign tick       = (pre_reg == PW'(TICK_DIV - 1));
  assign listen_end = (state_reg == S_LISTEN) && tick && (tcnt_reg == TCW'(WINDOW_US - 1));

  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    case (state_reg)
      S_IDLE: begin
        if (enable) begin
          p_next     = 2'd0;
          state_next = S_TRIG;
        end
      end
      S_TRIG: begin
        if (tick && tcnt_reg == TCW'(TRIG_US - 1)) state_next = S_LISTEN;
      end
      S_LISTEN: begin
        if (listen_end) state_next = S_STORE;
      end
      S_STORE: state_next = S_GAP;
      S_GAP: begin
        if (tick && tcnt_reg == TCW'(GAP_US - 1)) begin
          if (p_reg != 2'd2) begin
            p_next     = p_reg + 2'd1;
            state_next = S_TRIG;
          end else if (enable) begin
            p_next     = 2'd0;
            state_next = S_TRIG;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Prescaler restarts on state entry so every state lasts a whole number of ticks.
  always_comb begin
    entering  = (state_next != state_reg);
    pre_next  = '0;
    tcnt_next = tcnt_reg;
    if (entering) begin
      tcnt_next = '0;
    end else if (tick) begin
      tcnt_next = tcnt_reg + TCW'(1);
    end else begin
      pre_next  = pre_reg + PW'(1);
    end
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      state_reg      <= S_IDLE;
      p_reg          <= 2'd0;
      pre_reg        <= '0;
      tcnt_reg       <= '0;
      trig_reg       <= '0;
      busy_reg       <= 1'b0;
      cycle_done_reg <= 1'b0;
      sonar12_reg    <= 16'hFFFF;
      sonar34_reg    <= 16'hFFFF;
      sonar56_reg    <= 16'hFFFF;
    end else begin
      state_reg      <= state_next;
      p_reg          <= p_next;
      pre_reg        <= pre_next;
      tcnt_reg       <= tcnt_next;
      trig_reg       <= (state_next == S_TRIG) ? pair_mask(p_next) : 6'd0;
      busy_reg       <= (state_next != S_IDLE);
      cycle_done_reg <= (state_next == S_GAP) && (p_next == 2'd2) &&
                        (pre_next == PW'(TICK_DIV - 1)) && (tcnt_next == TCW'(GAP_US - 1));
      if (state_reg == S_STORE) begin
        case (p_reg)
          2'd1:    sonar34_reg <= dist_word;
          2'd2:    sonar56_reg <= dist_word;
          default: sonar12_reg <= dist_word;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : slot_g
      logic          started_reg, done_reg;
      logic [CW-1:0] cm_reg, cm_base;
      logic [7:0]    dist_reg, dist_base;
      logic          new_rise, counting;

      // The rise cycle itself counts, so a pulse of N ticks yields exactly N counted ticks.
      always_comb begin
        new_rise  = act_rise[gi] && !started_reg;
        counting  = new_rise || (started_reg && act_lvl[gi] && !done_reg);
        cm_base   = new_rise ? '0 : cm_reg;
        dist_base = new_rise ? 8'd0 : dist_reg;
      end

      always_ff @(posedge theClock or negedge theReset) begin
        if (!theReset) begin
          started_reg <= 1'b0;
          done_reg    <= 1'b0;
          cm_reg      <= '0;
          dist_reg    <= 8'd0;
        end else if (state_reg == S_TRIG) begin
          started_reg <= 1'b0;
          done_reg    <= 1'b0;
          cm_reg      <= '0;
          dist_reg    <= 8'd0;
        end else if (state_reg == S_LISTEN) begin
          if (listen_end) begin
            if (!done_reg) dist_reg <= 8'hFF;
          end else begin
            if (new_rise) started_reg <= 1'b1;
            if (act_fall[gi] && started_reg && !done_reg) done_reg <= 1'b1;
            if (counting) begin
              if (tick && cm_base == CW'(CM_US - 1)) begin
                cm_reg   <= '0;
                dist_reg <= (dist_base == 8'hFF) ? 8'hFF : dist_base + 8'd1;
              end else if (tick) begin
                cm_reg   <= cm_base + CW'(1);
                dist_reg <= dist_base;
              end else begin
                cm_reg   <= cm_base;
                dist_reg <= dist_base;
              end
            end
          end
        end
      end

      assign dist_word[15-8*gi -: 8] = dist_reg;
    end
  endgenerate

  assign trig       = trig_reg;
  assign busy       = busy_reg;
  assign cycle_done = cycle_done_reg;
  assign sonar12    = sonar12_reg;
  assign sonar34    = sonar34_reg;
  assign sonar56    = sonar56_reg;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler: table of per-pair echo scenarios plus
// hand-written reset, idle, cycle_done and enable-drop sequences.
module tb_sonar_scheduler;

  // Short CM and window keep two full cycles well inside the cycle budget.
  localparam int TD      = 2;
  localparam int TRIG    = 10;
  localparam int CM      = 8;
  localparam int WIN     = 2500;
  localparam int GAP     = 100;
  localparam int WIN_CYC = WIN * TD;

  logic        theClock = 1'b0;
  logic        theReset;
  logic        enable;
  logic [5:0]  echo;
  logic [5:0]  trig;
  logic [15:0] sonar12, sonar34, sonar56;
  logic        busy, cycle_done;

  int checks = 0;
  int failures = 0;
  int overlap_cnt = 0;
  int trig_nz_cnt = 0;
  int run_len = 0;
  int last_width = 0;
  int cd_cnt = 0;

  sonar_scheduler #(
    .TICK_DIV(TD), .TRIG_US(TRIG), .CM_US(CM), .WINDOW_US(WIN), .GAP_US(GAP)
  ) dut (
    .theClock(theClock), .theReset(theReset), .enable(enable), .echo(echo),
    .trig(trig), .sonar12(sonar12), .sonar34(sonar34), .sonar56(sonar56),
    .busy(busy), .cycle_done(cycle_done)
  );

  always #5 theClock = ~theClock;

  always @(negedge theClock) begin
    if (!(trig inside {6'b000000, 6'b000011, 6'b001100, 6'b110000})) overlap_cnt++;
    if (trig != 6'd0) begin
      trig_nz_cnt++;
      run_len++;
    end else if (run_len != 0) begin
      last_width = run_len;
      run_len = 0;
    end
    if (cycle_done) cd_cnt++;
  end

  typedef struct {
    logic [1:0]  pair;
    int          len_a;       // echo high time in ticks for sonar 2p+1, <0 = never rises
    int          len_b;
    bit          echo_in_trig;
    bit          drop_en;
    logic [15:0] exp_word;
    logic [5:0]  exp_after;   // trig expected one cycle after cycle_done (pair 2 only)
  } vec_t;

  vec_t vecs [6];

  function automatic logic [5:0] exp_mask(input logic [1:0] p);
    case (p)
      2'd1:    exp_mask = 6'b001100;
      2'd2:    exp_mask = 6'b110000;
      default: exp_mask = 6'b000011;
    endcase
  endfunction

  function automatic logic [15:0] word_of(input logic [1:0] p);
    case (p)
      2'd1:    word_of = sonar34;
      2'd2:    word_of = sonar56;
      default: word_of = sonar12;
    endcase
  endfunction

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for DUT", name);
    finish_tb();
  endtask

  task automatic wait_trig_high(input string name);
    int n = 0;
    do begin
      @(negedge theClock);
      n++;
    end while (trig == 6'd0 && n < 20000);
    if (trig == 6'd0) timeout(name);
  endtask

  task automatic wait_trig_low(input string name);
    int n = 0;
    do begin
      @(negedge theClock);
      n++;
    end while (trig != 6'd0 && n < 200);
    if (trig != 6'd0) timeout(name);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge theClock);
      n++;
    end while (!cycle_done && n < 1000);
    if (!cycle_done) timeout(name);
  endtask

  initial begin
    vecs[0] = '{2'd0, 80,   160,  1'b0, 1'b0, 16'h0A14, 6'h00};
    vecs[1] = '{2'd1, -1,   3000, 1'b0, 1'b0, 16'hFFFF, 6'h00};
    vecs[2] = '{2'd2, 2200, 40,   1'b0, 1'b0, 16'hFF05, 6'b000011};
    vecs[3] = '{2'd0, 20,   48,   1'b1, 1'b0, 16'hFF06, 6'h00};
    vecs[4] = '{2'd1, 16,   24,   1'b0, 1'b1, 16'h0203, 6'h00};
    vecs[5] = '{2'd2, 8,    -1,   1'b0, 1'b0, 16'h01FF, 6'h00};

    theReset = 1'b0;
    enable   = 1'b0;
    echo     = 6'd0;
    repeat (5) @(negedge theClock);
    chk("reset_trig", trig, 6'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_cycle_done", cycle_done, 1'b0);
    chk("reset_sonar12", sonar12, 16'hFFFF);
    chk("reset_sonar34", sonar34, 16'hFFFF);
    chk("reset_sonar56", sonar56, 16'hFFFF);
    $display("reset: trig=%0h busy=%0b words=%h/%h/%h", trig, busy, sonar12, sonar34, sonar56);

    theReset = 1'b1;
    trig_nz_cnt = 0;
    repeat (1000) @(negedge theClock);
    chk("idle_trig_quiet", trig_nz_cnt, 0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_sonar12", sonar12, 16'hFFFF);
    chk("idle_sonar56", sonar56, 16'hFFFF);
    $display("idle: 1000 cycles trig_active=%0d busy=%0b", trig_nz_cnt, busy);

    enable = 1'b1;
    @(negedge theClock);
    chk("enable_to_trig", trig, 6'b000011);

    for (int i = 0; i < 6; i++) begin
      int cd_before;
      wait_trig_high("trig_start");
      chk("trig_pair_mask", trig, exp_mask(vecs[i].pair));
      chk("busy_in_trig", busy, 1'b1);
      if (vecs[i].echo_in_trig) echo[2*vecs[i].pair] = 1'b1;
      wait_trig_low("trig_end");
      for (int c = 0; c < WIN_CYC; c++) begin
        echo[2*vecs[i].pair]   = (c < vecs[i].len_a * TD);
        echo[2*vecs[i].pair+1] = (c < vecs[i].len_b * TD);
        if (vecs[i].drop_en && c == 1000) enable = 1'b0;
        @(negedge theClock);
      end
      echo = 6'd0;
      cd_before = cd_cnt;
      repeat (10) @(negedge theClock);
      chk("pair_word", word_of(vecs[i].pair), vecs[i].exp_word);
      chk("trig_width", last_width, TD * TRIG);
      $display("vec %0d: pair=%0d len_a=%0d len_b=%0d word=%h exp=%h trig_width=%0d",
               i, vecs[i].pair, vecs[i].len_a, vecs[i].len_b,
               word_of(vecs[i].pair), vecs[i].exp_word, last_width);
      if (vecs[i].pair == 2'd2) begin
        wait_done("cycle_done");
        chk("done_trig_quiet", trig, 6'd0);
        @(negedge theClock);
        chk("done_single_pulse", cycle_done, 1'b0);
        chk("done_count", cd_cnt - cd_before, 1);
        chk("after_done_trig", trig, vecs[i].exp_after);
        chk("after_done_busy", busy, vecs[i].exp_after != 6'd0);
        $display("cycle_done: pulses=%0d next trig=%0h busy=%0b", cd_cnt - cd_before, trig, busy);
      end
    end

    trig_nz_cnt = 0;
    repeat (500) @(negedge theClock);
    chk("stopped_trig_quiet", trig_nz_cnt, 0);
    chk("stopped_busy", busy, 1'b0);
    chk("no_overlap", overlap_cnt, 0);
    $display("stopped: trig_active=%0d busy=%0b overlaps=%0d", trig_nz_cnt, busy, overlap_cnt);

    enable = 1'b1;
    wait_trig_high("rst_trig_start");
    repeat (5) @(negedge theClock);
    #1 theReset = 1'b0;
    #1;
    chk("rst_in_trig_trig", trig, 6'd0);
    chk("rst_in_trig_busy", busy, 1'b0);
    chk("rst_in_trig_sonar12", sonar12, 16'hFFFF);
    chk("rst_in_trig_sonar34", sonar34, 16'hFFFF);
    chk("rst_in_trig_sonar56", sonar56, 16'hFFFF);
    $display("reset in trig: trig=%0h busy=%0b words=%h/%h/%h", trig, busy, sonar12, sonar34, sonar56);
    @(negedge theClock);
    theReset = 1'b1;

    wait_trig_high("rst2_trig_start");
    wait_trig_low("rst2_trig_end");
    echo[0] = 1'b1;
    repeat (50) @(negedge theClock);
    #1 theReset = 1'b0;
    #1;
    chk("rst_in_listen_trig", trig, 6'd0);
    chk("rst_in_listen_busy", busy, 1'b0);
    chk("rst_in_listen_sonar12", sonar12, 16'hFFFF);
    $display("reset in listen: trig=%0h busy=%0b sonar12=%h", trig, busy, sonar12);
    echo = 6'd0;
    enable = 1'b0;
    @(negedge theClock);
    theReset = 1'b1;
    repeat (20) @(negedge theClock);
    chk("post_reset_idle", busy, 1'b0);

    finish_tb();
  end

endmodule
